multicycle_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32 datapath (R-type, load, store, BEQ). It replaces the single-cycle main decoder when instruction and data share one memory port.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Drives the shared-memory handshake and enforces a memory timeout.
- Raises a sticky trap on an illegal opcode or a stalled memory.

---
 rtl/ctrl_pkg.sv | 39 +++
 rtl/multicycle_ctrl_if.sv | 14 +
 rtl/ctrl_mem_timer.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 sequencer: states, opcodes,
// ALU selector codes and trap causes.
package ctrl_pkg;

   localparam int unsigned STATE_W = 4;
   localparam int unsigned OPC_W   = 7;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC_R = 4'd7,
      S_ALUWB  = 4'd8,
      S_BRANCH = 4'd9,
      S_TRAP   = 4'd15
   } state_e;

   localparam logic [OPC_W-1:0] OP_R     = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BEQ   = 7'b1100011;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory handshake.
//   mem_ready : memory completes the current read/write this cycle
//   mem_read  : read request
//   mem_write : write request
//   iord      : address select, 0 = PC, 1 = ALUOut
interface multicycle_ctrl_if;
   logic mem_ready;
   logic mem_read;
   logic mem_write;
   logic iord;

   modport master (input mem_ready, output mem_read, output mem_write, output iord);
   modport slave  (output mem_ready, input mem_read, input mem_write, input iord);
endinterface

// File: rtl/ctrl_mem_timer.sv
// Memory wait counter. Counts cycles spent waiting on memory and flags
// the cycle in which one more stall would exceed TIMEOUT.
//   clk, rst_n : clock, async active-low reset
//   active     : sequencer is in a memory-waiting state
//   ready      : memory completes this cycle
//   clear      : sequencer changes state this cycle
//   expired    : last permitted stall cycle with ready low
module ctrl_mem_timer #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic active,
   input  logic ready,
   input  logic clear,
   output logic expired
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Clear wins over increment so every new state starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (active && !ready) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = active && !ready && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 datapath (R-type, load, store, BEQ)
// sharing one memory port for instructions and data. Moore outputs are
// decoded from the state register so an async reset drops them at once.
//   clk, rst_n   : clock, async active-low reset
//   opcode       : IR[6:0], valid from DECODE onward
//   zero         : ALU zero flag
//   mem          : memory handshake (mem_ready in; mem_read, mem_write, iord out)
//   pc_write, ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b,
//   alu_op, pc_src : datapath controls
//   trap, trap_cause : sticky trap and its cause
//   state        : current state encoding for debug
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CW      = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [OPC_W-1:0]     opcode,
   input  logic                 zero,
   multicycle_ctrl_if.master    mem,
   output logic                 pc_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_write,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 pc_src,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [STATE_W-1:0]   state
);

   state_e     state_q, state_d;
   logic [1:0] cause_q, cause_d;
   logic       mem_wait;
   logic       expired;
   logic       iord_c, mem_read_c, mem_write_c;

   assign mem_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

   ctrl_mem_timer #(
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
   ) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .active  (mem_wait),
      .ready   (mem.mem_ready),
      .clear   (state_d != state_q),
      .expired (expired)
   );

   // Next-state and trap-cause selection.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (mem.mem_ready) begin
               state_d = S_DECODE;
            end else if (expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_R:              state_d = S_EXEC_R;
               OP_BEQ:            state_d = S_BRANCH;
               default: begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_ILLEGAL;
               end
            endcase
         end
         S_MEMADR: begin
            if (opcode == OP_LOAD) begin
               state_d = S_MEMRD;
            end else if (opcode == OP_STORE) begin
               state_d = S_MEMWR;
            end else begin
               // Opcode changed under us after DECODE; treat as illegal.
               state_d = S_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end
         end
         S_MEMRD: begin
            if (mem.mem_ready) begin
               state_d = S_MEMWB;
            end else if (expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_MEMWR: begin
            if (mem.mem_ready) begin
               state_d = S_FETCH;
            end else if (expired) begin
               state_d = S_TRAP;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         S_MEMWB:  state_d = S_FETCH;
         S_EXEC_R: state_d = S_ALUWB;
         S_ALUWB:  state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
   end

   // State and trap-cause registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // Moore output decode; only pc_write/ir_write are qualified by inputs.
   always_comb begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      iord_c      = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_RS2;
      alu_op      = ALU_ADD;
      pc_src      = 1'b0;
      trap        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            alu_src_b  = SRCB_FOUR;
            ir_write   = mem.mem_ready;
            pc_write   = mem.mem_ready;
         end
         S_DECODE: alu_src_b = SRCB_IMM;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write_c = 1'b1;
            iord_c      = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_FUNCT;
         end
         S_ALUWB: reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         S_TRAP: trap = 1'b1;
         default: ;
      endcase
   end

   assign mem.mem_read  = mem_read_c;
   assign mem.mem_write = mem_write_c;
   assign mem.iord      = iord_c;
   assign trap_cause    = cause_q;
   assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle pushes the
// hand-derived expected output vector; a negedge monitor pops and compares.
module tb_multicycle_ctrl;

   localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                          ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5,
                          ST_MEMWR = 4'd6, ST_EXEC_R = 4'd7, ST_ALUWB = 4'd8,
                          ST_BRANCH = 4'd9, ST_TRAP = 4'd15;
   localparam logic [6:0] O_R = 7'b0110011, O_LD = 7'b0000011,
                          O_ST = 7'b0100011, O_BEQ = 7'b1100011, O_BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic       zero;
   logic       pc_write, ir_write, mem_to_reg, reg_write, alu_src_a, pc_src, trap;
   logic [1:0] alu_src_b, alu_op, trap_cause;
   logic [3:0] state;

   multicycle_ctrl_if mif ();

   multicycle_ctrl #(.TIMEOUT(16), .CW(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem        (mif),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .trap       (trap),
      .trap_cause (trap_cause),
      .state      (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [19:0] v;
      string       nm;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Expected vector from the per-state output table:
   // {state, cause, trap, pc_write, ir_write, iord, mem_read, mem_write,
   //  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src}
   function automatic logic [19:0] ev(input logic [3:0] st, input logic rdy,
                                      input logic z, input logic [1:0] cause);
      logic pcw, irw, io, mr, mw, m2r, rw, sa, pcs, tr;
      logic [1:0] sb, ao;
      {pcw, irw, io, mr, mw, m2r, rw, sa, pcs, tr} = '0;
      sb = 2'b00;
      ao = 2'b00;
      case (st)
         ST_FETCH:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
         ST_DECODE: sb = 2'b10;
         ST_MEMADR: begin sa = 1'b1; sb = 2'b10; end
         ST_MEMRD:  begin mr = 1'b1; io = 1'b1; end
         ST_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
         ST_MEMWR:  begin mw = 1'b1; io = 1'b1; end
         ST_EXEC_R: begin sa = 1'b1; ao = 2'b10; end
         ST_ALUWB:  rw = 1'b1;
         ST_BRANCH: begin sa = 1'b1; ao = 2'b01; pcs = 1'b1; pcw = z; end
         ST_TRAP:   tr = 1'b1;
         default: ;
      endcase
      return {st, cause, tr, pcw, irw, io, mr, mw, m2r, rw, sa, sb, ao, pcs};
   endfunction

   // One stimulus cycle: drive inputs just after the edge, queue expectation.
   task automatic cyc(input logic [3:0] st, input logic r, input logic [6:0] op,
                      input logic rdy, input logic z, input logic [1:0] cause,
                      input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n         = r;
      opcode        = op;
      mif.mem_ready = rdy;
      zero          = z;
      e.v  = ev(st, rdy, z, cause);
      e.nm = nm;
      q.push_back(e);
   endtask

   // Monitor: compare the full output vector mid-cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [19:0] act;
         e   = q.pop_front();
         act = {state, trap_cause, trap, pc_write, ir_write, mif.iord, mif.mem_read,
                mif.mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};
         n_cmp++;
         if (act !== e.v) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", e.nm, act, e.v);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      opcode        = 7'd0;
      zero          = 1'b0;
      mif.mem_ready = 1'b0;

      // Reset, then R-type
      cyc(ST_IDLE,   1'b0, O_R, 1'b1, 1'b0, 2'b00, "reset");
      cyc(ST_IDLE,   1'b1, O_R, 1'b1, 1'b0, 2'b00, "reset_release");
      cyc(ST_FETCH,  1'b1, O_R, 1'b1, 1'b0, 2'b00, "r_fetch");
      cyc(ST_DECODE, 1'b1, O_R, 1'b1, 1'b0, 2'b00, "r_decode");
      cyc(ST_EXEC_R, 1'b1, O_R, 1'b1, 1'b0, 2'b00, "r_exec");
      cyc(ST_ALUWB,  1'b1, O_R, 1'b1, 1'b0, 2'b00, "r_aluwb");

      // Load with three wait cycles in MEMRD
      cyc(ST_FETCH,  1'b1, O_LD, 1'b1, 1'b0, 2'b00, "ld_fetch");
      cyc(ST_DECODE, 1'b1, O_LD, 1'b1, 1'b0, 2'b00, "ld_decode");
      cyc(ST_MEMADR, 1'b1, O_LD, 1'b1, 1'b0, 2'b00, "ld_memadr");
      for (int i = 0; i < 3; i++)
         cyc(ST_MEMRD, 1'b1, O_LD, 1'b0, 1'b0, 2'b00, "ld_memrd_wait");
      cyc(ST_MEMRD,  1'b1, O_LD, 1'b1, 1'b0, 2'b00, "ld_memrd_done");
      cyc(ST_MEMWB,  1'b1, O_LD, 1'b1, 1'b0, 2'b00, "ld_memwb");

      // BEQ taken and not taken
      cyc(ST_FETCH,  1'b1, O_BEQ, 1'b1, 1'b0, 2'b00, "beq1_fetch");
      cyc(ST_DECODE, 1'b1, O_BEQ, 1'b1, 1'b0, 2'b00, "beq1_decode");
      cyc(ST_BRANCH, 1'b1, O_BEQ, 1'b1, 1'b1, 2'b00, "beq_taken");
      cyc(ST_FETCH,  1'b1, O_BEQ, 1'b1, 1'b0, 2'b00, "beq0_fetch");
      cyc(ST_DECODE, 1'b1, O_BEQ, 1'b1, 1'b0, 2'b00, "beq0_decode");
      cyc(ST_BRANCH, 1'b1, O_BEQ, 1'b1, 1'b0, 2'b00, "beq_not_taken");

      // mem_ready arrives in the 16th FETCH cycle: no trap
      for (int i = 0; i < 15; i++)
         cyc(ST_FETCH, 1'b1, O_R, 1'b0, 1'b0, 2'b00, "fetch_wait15");
      cyc(ST_FETCH,  1'b1, O_R, 1'b1, 1'b0, 2'b00, "fetch_ready16");
      cyc(ST_DECODE, 1'b1, O_R, 1'b1, 1'b0, 2'b00, "late_ready_decode");
      cyc(ST_EXEC_R, 1'b1, O_R, 1'b1, 1'b0, 2'b00, "late_ready_exec");
      cyc(ST_ALUWB,  1'b1, O_R, 1'b1, 1'b0, 2'b00, "late_ready_aluwb");

      // 16 stalled FETCH cycles: timeout trap
      for (int i = 0; i < 16; i++)
         cyc(ST_FETCH, 1'b1, O_R, 1'b0, 1'b0, 2'b00, "fetch_stall");
      for (int i = 0; i < 4; i++)
         cyc(ST_TRAP, 1'b1, O_R, 1'b1, 1'b0, 2'b10, "timeout_trap");
      cyc(ST_IDLE,   1'b0, O_R, 1'b1, 1'b0, 2'b00, "trap_reset");
      cyc(ST_IDLE,   1'b1, O_R, 1'b1, 1'b0, 2'b00, "trap_reset_release");

      // Illegal opcode: trap held for 22 cycles, reset exits
      cyc(ST_FETCH,  1'b1, O_BAD, 1'b1, 1'b0, 2'b00, "ill_fetch");
      cyc(ST_DECODE, 1'b1, O_BAD, 1'b1, 1'b0, 2'b00, "ill_decode");
      for (int i = 0; i < 22; i++)
         cyc(ST_TRAP, 1'b1, O_BAD, (i % 2) == 0, 1'b1, 2'b01, "illegal_trap");
      cyc(ST_IDLE,   1'b0, O_ST, 1'b1, 1'b0, 2'b00, "ill_reset");
      cyc(ST_IDLE,   1'b1, O_ST, 1'b1, 1'b0, 2'b00, "ill_reset_release");

      // Store, then async reset while MEMWR waits
      cyc(ST_FETCH,  1'b1, O_ST, 1'b1, 1'b0, 2'b00, "st_fetch");
      cyc(ST_DECODE, 1'b1, O_ST, 1'b1, 1'b0, 2'b00, "st_decode");
      cyc(ST_MEMADR, 1'b1, O_ST, 1'b1, 1'b0, 2'b00, "st_memadr");
      cyc(ST_MEMWR,  1'b1, O_ST, 1'b0, 1'b0, 2'b00, "st_memwr");
      @(negedge clk);
      #2;
      n_cmp++;
      if (mif.mem_write !== 1'b1) begin
         n_err++;
         $display("FAIL st_memwr_pre_reset: mem_write got %b expected 1", mif.mem_write);
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (mif.mem_write !== 1'b0 || state !== ST_IDLE) begin
         n_err++;
         $display("FAIL async_reset: mem_write got %b expected 0, state got %0d expected 0",
                  mif.mem_write, state);
      end
      cyc(ST_IDLE,   1'b0, O_ST, 1'b1, 1'b0, 2'b00, "async_reset_hold");
      cyc(ST_IDLE,   1'b1, O_ST, 1'b1, 1'b0, 2'b00, "async_reset_release");
      cyc(ST_FETCH,  1'b1, O_ST, 1'b1, 1'b0, 2'b00, "post_reset_fetch");

      repeat (2) @(posedge clk);
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
